// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core.
// Sequences lw, sw, R-ALU, I-ALU, beq/bne, jal and jalr through
// FETCH/DECODE/EXECUTE/MEM/WB states, steers the datapath muxes, drives the
// immediate type and handshakes with the shared instruction/data memory.
// Unsupported opcodes and memory timeouts park the FSM in TRAP until reset.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_inst           instruction register contents
//   i_zero           ALU zero flag (current cycle)
//   i_mem_ready      memory accepts/returns the access this cycle
//   o_mem_req        memory request, o_mem_write qualifies it as a store
//   o_adr_src        0=PC, 1=ALUOut as memory address
//   o_ir_write       load instruction/old-PC registers
//   o_pc_write       load PC from result bus
//   o_reg_write      write rd from result bus
//   o_alu_src_a/b    ALU operand selects
//   o_alu_op         00=add 01=sub 10=funct-decoded
//   o_result_src     00=ALUOut 01=mem rdata 10=ALU result
//   o_imm_type       000=I 001=S 010=B 011=J
//   o_instr_done     one-cycle pulse on the last cycle of each instruction
//   o_trap           sticky trap flag, o_trap_cause 0=illegal 1=mem timeout
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_inst,
    input  logic        i_zero,
    input  logic        i_mem_ready,
    output logic        o_mem_req,
    output logic        o_mem_write,
    output logic        o_adr_src,
    output logic        o_ir_write,
    output logic        o_pc_write,
    output logic        o_reg_write,
    output logic [1:0]  o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [1:0]  o_alu_op,
    output logic [1:0]  o_result_src,
    output logic [2:0]  o_imm_type,
    output logic        o_instr_done,
    output logic        o_trap,
    output logic        o_trap_cause
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Waiting cycle number MEM_TIMEOUT is the one whose count equals this.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB, S_EXEC_R,
        S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_LINK, S_TRAP
    } state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_tmo_cnt;
    logic        r_trap, r_trap_cause;
    logic        w_wait, w_wait_next, w_tmo_hit;
    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic        w_unused;

    assign w_op     = i_inst[6:0];
    assign w_f3     = i_inst[14:12];
    assign w_unused = ^{i_inst[31:15], i_inst[11:7]};

    assign w_wait      = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_wait_next = (w_next == S_FETCH) || (w_next == S_MEMRD) || (w_next == S_MEMWR);
    // A ready in the final allowed cycle still counts as normal progress.
    assign w_tmo_hit   = w_wait && !i_mem_ready && (r_tmo_cnt == TMO_LAST);

    assign o_trap       = r_trap;
    assign o_trap_cause = r_trap_cause;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_FETCH;
            r_tmo_cnt    <= '0;
            r_trap       <= 1'b0;
            r_trap_cause <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP && r_state != S_TRAP) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_tmo_hit;
            end
            if (w_wait_next && w_next != r_state)
                r_tmo_cnt <= '0;
            else if (w_wait && !i_mem_ready)
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    always_comb begin
        case (w_op)
            OP_LW, OP_I, OP_JALR: o_imm_type = 3'b000;
            OP_SW:                o_imm_type = 3'b001;
            OP_BR:                o_imm_type = 3'b010;
            OP_JAL:               o_imm_type = 3'b011;
            default:              o_imm_type = 3'b000;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        o_mem_req    = 1'b0;
        o_mem_write  = 1'b0;
        o_adr_src    = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_reg_write  = 1'b0;
        o_alu_src_a  = 2'b00;
        o_alu_src_b  = 2'b00;
        o_alu_op     = 2'b00;
        o_result_src = 2'b00;
        o_instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_mem_req    = 1'b1;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                o_ir_write   = i_mem_ready;
                o_pc_write   = i_mem_ready;
                if (i_mem_ready)    w_next = S_DECODE;
                else if (w_tmo_hit) w_next = S_TRAP;
            end
            S_DECODE: begin
                // ALUOut <= oldPC + imm, the branch/jal target.
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b01;
                case (w_op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXEC_R;
                    OP_I:         w_next = S_EXEC_I;
                    OP_BR:        w_next = (w_f3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                    OP_JAL:       w_next = S_JAL;
                    OP_JALR:      w_next = S_JALR;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
                w_next      = (w_op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                o_mem_req = 1'b1;
                o_adr_src = 1'b1;
                if (i_mem_ready)    w_next = S_MEMWB;
                else if (w_tmo_hit) w_next = S_TRAP;
            end
            S_MEMWB: begin
                o_result_src = 2'b01;
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                o_mem_req    = 1'b1;
                o_mem_write  = 1'b1;
                o_adr_src    = 1'b1;
                o_instr_done = i_mem_ready;
                if (i_mem_ready)    w_next = S_FETCH;
                else if (w_tmo_hit) w_next = S_TRAP;
            end
            S_EXEC_R, S_EXEC_I: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = (r_state == S_EXEC_I) ? 2'b01 : 2'b00;
                o_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                // funct3[0] distinguishes bne (taken when not equal) from beq.
                o_alu_src_a  = 2'b10;
                o_alu_op     = 2'b01;
                o_pc_write   = i_zero ^ w_f3[0];
                o_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_JAL: begin
                // PC <= target held in ALUOut while the ALU forms oldPC+4 for the link.
                o_pc_write  = 1'b1;
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b10;
                w_next      = S_ALUWB;
            end
            S_JALR: begin
                o_alu_src_a  = 2'b10;
                o_alu_src_b  = 2'b01;
                o_result_src = 2'b10;
                o_pc_write   = 1'b1;
                w_next       = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                o_alu_src_a  = 2'b01;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
        if (i_rst) begin
            o_mem_req    = 1'b0;
            o_mem_write  = 1'b0;
            o_ir_write   = 1'b0;
            o_pc_write   = 1'b0;
            o_reg_write  = 1'b0;
            o_instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. Each instruction is expanded by a small
// reference model into its expected cycle-by-cycle control outputs, with
// randomized memory latency, zero flag and don't-care inputs.
module tb_multicycle_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0]  imm_type;
    logic        instr_done, trap, trap_cause;

    int checks = 0;
    int errors = 0;
    int obs_done = 0;
    int retired = 0;

    logic [31:0] g_inst;
    logic [2:0]  m_imm;
    logic        m_trap = 1'b0;
    logic        m_cause = 1'b0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(rst), .i_inst(inst), .i_zero(zero), .i_mem_ready(mem_ready),
        .o_mem_req(mem_req), .o_mem_write(mem_write), .o_adr_src(adr_src),
        .o_ir_write(ir_write), .o_pc_write(pc_write), .o_reg_write(reg_write),
        .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_op(alu_op),
        .o_result_src(result_src), .o_imm_type(imm_type), .o_instr_done(instr_done),
        .o_trap(trap), .o_trap_cause(trap_cause)
    );

    // Control word: {req,wr,adr,ir,pc,rw,src_a,src_b,alu_op,res_src,done}
    function automatic logic [14:0] c(input logic req, input logic wr, input logic adr,
                                      input logic ir, input logic pc, input logic rw,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] op, input logic [1:0] rs,
                                      input logic done);
        return {req, wr, adr, ir, pc, rw, sa, sb, op, rs, done};
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs at negedge, compare just after.
    task automatic step(input string tag, input logic mr, input logic z, input logic [14:0] ctl);
        logic [19:0] exp_v, obs_v;
        @(negedge clk);
        rst = 1'b0;
        inst = g_inst;
        mem_ready = mr;
        zero = z;
        #1;
        exp_v = {ctl, m_imm, m_trap, m_cause};
        obs_v = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, alu_src_a,
                 alu_src_b, alu_op, result_src, instr_done, imm_type, trap, trap_cause};
        checks++;
        if (instr_done) obs_done++;
        assert (obs_v === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs_v, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = rb();
        #1;
        checks++;
        assert ({mem_req, mem_write, ir_write, pc_write, reg_write, instr_done} === 6'b0)
        else begin
            errors++;
            $error("FAIL reset_enables: observed %b expected 000000",
                   {mem_req, mem_write, ir_write, pc_write, reg_write, instr_done});
        end
        @(negedge clk);
        #1;
        checks++;
        assert ({trap, trap_cause, mem_write, reg_write, instr_done} === 5'b0)
        else begin
            errors++;
            $error("FAIL reset_trap: observed %b expected 00000",
                   {trap, trap_cause, mem_write, reg_write, instr_done});
        end
        m_trap = 1'b0;
        m_cause = 1'b0;
    endtask

    task automatic trap_cycles(input string tag);
        for (int i = 0; i < 3; i++) step(tag, rb(), rb(), 15'b0);
    endtask

    // Memory wait: lat cycles without ready, then a ready cycle; TMO misses traps.
    task automatic wait_phase(input string tag, input logic [14:0] cw, input logic [14:0] cr,
                              input int lat, output bit tout);
        tout = (lat >= TMO);
        for (int i = 0; i < (tout ? TMO : lat); i++) step(tag, 1'b0, rb(), cw);
        if (tout) begin
            m_trap = 1'b1;
            m_cause = 1'b1;
            trap_cycles({tag, "_tmo"});
        end else begin
            step(tag, 1'b1, rb(), cr);
        end
    endtask

    task automatic run(input string nm, input logic [31:0] ins, input int lf, input int lm,
                       input logic zb);
        bit t;
        logic [6:0] op;
        logic [2:0] f3;
        logic take;
        op = ins[6:0];
        f3 = ins[14:12];
        g_inst = ins;
        m_imm = imm_of(op);
        wait_phase({nm, "_fetch"}, c(1,0,0,0,0,0,2'd0,2'd2,2'd0,2'd2,0),
                   c(1,0,0,1,1,0,2'd0,2'd2,2'd0,2'd2,0), lf, t);
        if (t) return;
        step({nm, "_decode"}, rb(), rb(), c(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,0));
        case (op)
            7'b0110011, 7'b0010011: begin
                step({nm, "_exec"}, rb(), rb(),
                     c(0,0,0,0,0,0,2'd2,(op == 7'b0010011) ? 2'd1 : 2'd0,2'd2,2'd0,0));
                step({nm, "_aluwb"}, rb(), rb(), c(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,1));
                retired++;
            end
            7'b0000011: begin
                step({nm, "_memadr"}, rb(), rb(), c(0,0,0,0,0,0,2'd2,2'd1,2'd0,2'd0,0));
                wait_phase({nm, "_memrd"}, c(1,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,0),
                           c(1,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,0), lm, t);
                if (t) return;
                step({nm, "_memwb"}, rb(), rb(), c(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd1,1));
                retired++;
            end
            7'b0100011: begin
                step({nm, "_memadr"}, rb(), rb(), c(0,0,0,0,0,0,2'd2,2'd1,2'd0,2'd0,0));
                wait_phase({nm, "_memwr"}, c(1,1,1,0,0,0,2'd0,2'd0,2'd0,2'd0,0),
                           c(1,1,1,0,0,0,2'd0,2'd0,2'd0,2'd0,1), lm, t);
                if (t) return;
                retired++;
            end
            7'b1100011: begin
                if (f3 == 3'b000 || f3 == 3'b001) begin
                    take = (f3 == 3'b000) ? zb : !zb;
                    step({nm, "_branch"}, rb(), zb, c(0,0,0,0,take,0,2'd2,2'd0,2'd1,2'd0,1));
                    retired++;
                end else begin
                    m_trap = 1'b1;
                    m_cause = 1'b0;
                    trap_cycles({nm, "_trap"});
                end
            end
            7'b1101111: begin
                step({nm, "_jal"}, rb(), rb(), c(0,0,0,0,1,0,2'd1,2'd2,2'd0,2'd0,0));
                step({nm, "_aluwb"}, rb(), rb(), c(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,1));
                retired++;
            end
            7'b1100111: begin
                step({nm, "_jalr"}, rb(), rb(), c(0,0,0,0,1,0,2'd2,2'd1,2'd0,2'd2,0));
                step({nm, "_link"}, rb(), rb(), c(0,0,0,0,0,1,2'd1,2'd2,2'd0,2'd2,1));
                retired++;
            end
            default: begin
                m_trap = 1'b1;
                m_cause = 1'b0;
                trap_cycles({nm, "_trap"});
            end
        endcase
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        logic [31:0] r;
        r = $urandom;
        return {r[31:15], f3, r[11:7], op};
    endfunction

    function automatic logic [31:0] rand_inst(input int cls);
        case (cls)
            0: return mk(7'b0110011, 3'($urandom));
            1: return mk(7'b0010011, 3'($urandom));
            2: return mk(7'b0000011, 3'b010);
            3: return mk(7'b0100011, 3'b010);
            4: return mk(7'b1100011, 3'b000);
            5: return mk(7'b1100011, 3'b001);
            6: return mk(7'b1101111, 3'($urandom));
            default: return mk(7'b1100111, 3'b000);
        endcase
    endfunction

    initial begin
        g_inst = 32'h0;
        m_imm = 3'b000;
        do_reset();
        run("add", 32'h002081B3, 0, 0, 1'b0);
        run("lw_delay3", 32'h0080A283, 0, 3, 1'b0);
        run("beq_z1", mk(7'b1100011, 3'b000), 0, 0, 1'b1);
        run("bne_z1", mk(7'b1100011, 3'b001), 0, 0, 1'b1);
        run("beq_z0", mk(7'b1100011, 3'b000), 1, 0, 1'b0);
        run("bne_z0", mk(7'b1100011, 3'b001), 0, 0, 1'b0);
        run("jalr", mk(7'b1100111, 3'b000), 0, 0, 1'b0);
        run("jal", mk(7'b1101111, 3'b000), 2, 0, 1'b0);
        run("sw", mk(7'b0100011, 3'b010), 0, 2, 1'b0);
        run("addi", mk(7'b0010011, 3'b000), 3, 0, 1'b0);
        for (int i = 0; i < 40; i++)
            run($sformatf("rnd%0d", i), rand_inst(int'($urandom_range(0, 7))),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb());
        run("lui", 32'h000012B7, 0, 0, 1'b0);
        do_reset();
        run("blt_illegal", mk(7'b1100011, 3'b100), 1, 0, 1'b0);
        do_reset();
        run("fetch_tmo", mk(7'b0110011, 3'b000), TMO, 0, 1'b0);
        do_reset();
        run("lw_tmo", mk(7'b0000011, 3'b010), 0, TMO, 1'b0);
        do_reset();
        run("sw_tmo", mk(7'b0100011, 3'b010), 2, TMO, 1'b0);
        do_reset();
        run("post_rst_add", 32'h002081B3, 1, 0, 1'b0);
        checks++;
        assert (obs_done === retired)
        else begin
            errors++;
            $error("FAIL done_count: observed %0d expected %0d", obs_done, retired);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
